// File: rtl/oht_pkg.sv
// Shared types and constants for the OHT SRAM controller.
// Holds the controller state enum and curr_state field positions.
package oht_pkg;

  localparam int OHT_W = 32;
  localparam int SEL_W = 6;

  localparam int OSEL_LSB = 0;
  localparam int OSEL_MSB = 5;
  localparam int ISEL_LSB = 6;
  localparam int ISEL_MSB = 11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RD_DATA = 2'd2
  } oht_state_e;

endpackage

// File: rtl/oht_sram_ptr.sv
// Circular FIFO pointers for the OHT SRAM controller.
// Write/read pointers wrap naturally at 2**ADDR_W; count drives full/empty.
module oht_sram_ptr #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_wr,
  input  logic              inc_rd,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE = 1;
  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (inc_wr)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (inc_rd)
        rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({inc_wr, inc_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == DEPTH);
  assign empty = (count == '0);

endmodule

// File: rtl/oht_sram_ctrl.sv
// Single-port SRAM FIFO controller for one entropy path.
// Mux debug/select outputs are registered only when OHT_SRAM_DBG_EN is defined.
module oht_sram_ctrl
  import oht_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = OHT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              oht_valid,
  output logic              sram_we,
  output logic              sram_re,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              dbg_req,
  input  logic [23:0]       curr_state,
  output logic              debug,
  output logic [SEL_W-1:0]  output_select,
  output logic [SEL_W-1:0]  input_select
);

  oht_state_e state_q;
  oht_state_e state_d;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;

  logic active;
  logic wr_go;
  logic rd_go;
  logic ovf_set;

  assign active  = (state_q != IDLE) & enable;
  assign wr_go   = active & oht_valid & ~full;
  assign ovf_set = active & oht_valid & full;

  // rd_valid marks the request as served; the conditioner drops rd_req after it
  assign rd_go = (state_q == RUN) & enable & rd_req & ~empty
               & ~rd_valid & ~(oht_valid & ~full);

  oht_sram_ptr #(
    .ADDR_W (ADDR_W)
  ) u_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_wr (wr_go),
    .inc_rd (rd_go),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN: begin
        if (!enable)
          state_d = IDLE;
        else if (rd_go)
          state_d = RD_DATA;
      end
      RD_DATA: state_d = enable ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sram_we = wr_go;
  assign sram_re = rd_go;

  always_comb begin
    sram_addr = '0;
    unique case (1'b1)
      wr_go:   sram_addr = wr_ptr;
      rd_go:   sram_addr = rd_ptr;
      default: sram_addr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      overflow <= 1'b0;
    end else begin
      rd_valid <= (state_q == RD_DATA);
      if (state_q == RD_DATA)
        rd_data <= sram_rdata;
      if (ovf_set)
        overflow <= 1'b1;
    end
  end

`ifdef OHT_SRAM_DBG_EN
  logic unused_cs_hi;
  assign unused_cs_hi = ^curr_state[23:ISEL_MSB+1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      debug         <= 1'b0;
      output_select <= '0;
      input_select  <= '0;
    end else begin
      debug         <= dbg_req;
      output_select <= curr_state[OSEL_MSB:OSEL_LSB];
      input_select  <= curr_state[ISEL_MSB:ISEL_LSB];
    end
  end
`else
  logic unused_dbg_in;
  assign unused_dbg_in = ^{dbg_req, curr_state};

  assign debug         = 1'b0;
  assign output_select = '0;
  assign input_select  = '0;
`endif

endmodule
